// File: rtl/mandelbrot_host_driver_if.sv
// Bundle of the host request/result handshakes and the accelerator byte bus.
// The driver uses the slave view. The host and accelerator side uses the master view.
interface mandelbrot_host_driver_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_cr;
  logic [31:0] req_ci;
  logic [6:0]  req_max_iter;
  logic        res_valid;
  logic        res_ready;
  logic [6:0]  res_iter;
  logic        res_escaped;
  logic [7:0]  acc_data;
  logic        acc_start;
  logic        acc_load_cr;
  logic        acc_load_ci;
  logic [6:0]  acc_iter;
  logic        acc_unbounded;

  modport master (
    output req_valid, req_cr, req_ci, req_max_iter, res_ready, acc_iter, acc_unbounded,
    input  req_ready, res_valid, res_iter, res_escaped,
           acc_data, acc_start, acc_load_cr, acc_load_ci
  );

  modport slave (
    input  req_valid, req_cr, req_ci, req_max_iter, res_ready, acc_iter, acc_unbounded,
    output req_ready, res_valid, res_iter, res_escaped,
           acc_data, acc_start, acc_load_cr, acc_load_ci
  );
endinterface

// File: rtl/mandelbrot_host_driver.sv
// Host-side driver for the Mandelbrot accelerator: serialises Cr/Ci over the byte bus,
// watches the iteration counter and returns the escape result through a valid/ready handshake.
module mandelbrot_host_driver (
  input logic                      clk,
  input logic                      rst_n,
  mandelbrot_host_driver_if.slave  bus
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SEND_CR = 3'd1;
  localparam logic [2:0] ST_SEND_CI = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_RESULT  = 3'd4;

  logic [2:0]  state_q,       state_d;
  logic [1:0]  idx_q,         idx_d;
  logic [31:0] cr_q,          cr_d;
  logic [31:0] ci_q,          ci_d;
  logic [6:0]  lim_q,         lim_d;
  logic        req_ready_q,   req_ready_d;
  logic        res_valid_q,   res_valid_d;
  logic [6:0]  res_iter_q,    res_iter_d;
  logic        res_escaped_q, res_escaped_d;
  logic [7:0]  acc_data_q,    acc_data_d;
  logic        acc_start_q,   acc_start_d;
  logic        acc_load_cr_q, acc_load_cr_d;
  logic        acc_load_ci_q, acc_load_ci_d;

  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

  // Next-state logic. The byte index names the byte that is on the bus after the edge.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cr_d          = cr_q;
    ci_d          = ci_q;
    lim_d         = lim_q;
    req_ready_d   = req_ready_q;
    res_valid_d   = res_valid_q;
    res_iter_d    = res_iter_q;
    res_escaped_d = res_escaped_q;
    acc_data_d    = 8'h00;
    acc_start_d   = 1'b0;
    acc_load_cr_d = 1'b0;
    acc_load_ci_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          state_d     = ST_SEND_CR;
          idx_d       = 2'd0;
          cr_d        = bus.req_cr;
          ci_d        = bus.req_ci;
          lim_d       = (bus.req_max_iter == 7'd0) ? 7'd127 : bus.req_max_iter;
          acc_data_d  = bus.req_cr[7:0];
          req_ready_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND_CR: begin
        if (idx_q != 2'd3) begin
          idx_d         = idx_q + 2'd1;
          acc_data_d    = byte_sel(cr_q, idx_d);
          acc_load_cr_d = (idx_d == 2'd3);
        end else begin
          state_d    = ST_SEND_CI;
          idx_d      = 2'd0;
          acc_data_d = ci_q[7:0];
        end
      end
      ST_SEND_CI: begin
        if (idx_q != 2'd3) begin
          idx_d         = idx_q + 2'd1;
          acc_data_d    = byte_sel(ci_q, idx_d);
          acc_load_ci_d = (idx_d == 2'd3);
          acc_start_d   = (idx_d == 2'd3);
        end else begin
          state_d = ST_WAIT;
          idx_d   = 2'd0;
        end
      end
      ST_WAIT: begin
        // Divergence wins over the limit when both happen on the same iteration.
        if (bus.acc_unbounded) begin
          state_d       = ST_RESULT;
          res_valid_d   = 1'b1;
          res_iter_d    = bus.acc_iter;
          res_escaped_d = 1'b1;
        end else if (bus.acc_iter == lim_q) begin
          state_d       = ST_RESULT;
          res_valid_d   = 1'b1;
          res_iter_d    = lim_q;
          res_escaped_d = 1'b0;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESULT: begin
        if (res_valid_q && bus.res_ready) begin
          state_d     = ST_IDLE;
          res_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end else begin
          state_d = ST_RESULT;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        idx_d       = 2'd0;
        res_valid_d = 1'b0;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= 2'd0;
      cr_q          <= 32'h0000_0000;
      ci_q          <= 32'h0000_0000;
      lim_q         <= 7'd0;
      req_ready_q   <= 1'b1;
      res_valid_q   <= 1'b0;
      res_iter_q    <= 7'd0;
      res_escaped_q <= 1'b0;
      acc_data_q    <= 8'h00;
      acc_start_q   <= 1'b0;
      acc_load_cr_q <= 1'b0;
      acc_load_ci_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cr_q          <= cr_d;
      ci_q          <= ci_d;
      lim_q         <= lim_d;
      req_ready_q   <= req_ready_d;
      res_valid_q   <= res_valid_d;
      res_iter_q    <= res_iter_d;
      res_escaped_q <= res_escaped_d;
      acc_data_q    <= acc_data_d;
      acc_start_q   <= acc_start_d;
      acc_load_cr_q <= acc_load_cr_d;
      acc_load_ci_q <= acc_load_ci_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_iter    = res_iter_q;
  assign bus.res_escaped = res_escaped_q;
  assign bus.acc_data    = acc_data_q;
  assign bus.acc_start   = acc_start_q;
  assign bus.acc_load_cr = acc_load_cr_q;
  assign bus.acc_load_ci = acc_load_ci_q;

endmodule

// File: tb/tb_mandelbrot_host_driver.sv
// Directed bench for mandelbrot_host_driver with a simple iterating accelerator model.
module tb_mandelbrot_host_driver;

  logic clk;
  logic rst_n;
  logic [6:0] div_at;
  int tests_run;
  int tests_failed;

  mandelbrot_host_driver_if bus ();

  mandelbrot_host_driver dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accelerator model: counter restarts at 1 on start, flags divergence when it reaches div_at.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.acc_iter      <= 7'd0;
      bus.acc_unbounded <= 1'b0;
    end else if (bus.acc_start) begin
      bus.acc_iter      <= 7'd1;
      bus.acc_unbounded <= (div_at == 7'd1);
    end else begin
      bus.acc_iter      <= bus.acc_iter + 7'd1;
      bus.acc_unbounded <= (div_at != 7'd0) && ((bus.acc_iter + 7'd1) == div_at);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_req(input logic [31:0] cr, input logic [31:0] ci, input logic [6:0] mi);
    int n;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_cr       = cr;
    bus.req_ci       = ci;
    bus.req_max_iter = mi;
    bus.req_valid    = 1'b1;
    @(negedge clk);
    bus.req_valid    = 1'b0;
  endtask

  // One full transaction; latency counts rising edges after the request handshake edge.
  task automatic run_req(input logic [31:0] cr, input logic [31:0] ci, input logic [6:0] mi,
                         input logic [6:0] div, input logic [6:0] e_iter, input logic e_esc,
                         input int e_lat, input int hold);
    int edges;
    logic [63:0] seq;
    div_at        = div;
    bus.res_ready = (hold == 0);
    send_req(cr, ci, mi);
    seq = {ci, cr};
    check("req_ready_busy", 32'(bus.req_ready), 32'd0);
    for (int k = 0; k < 8; k++) begin
      check("acc_data", 32'(bus.acc_data), 32'(seq[8*k +: 8]));
      check("load_cr", 32'(bus.acc_load_cr), 32'(k == 3));
      check("load_ci", 32'(bus.acc_load_ci), 32'(k == 7));
      check("start", 32'(bus.acc_start), 32'(k == 7));
      @(negedge clk);
    end
    edges = 8;
    check("wait_data_zero", 32'(bus.acc_data), 32'd0);
    while (!bus.res_valid && edges < 300) begin
      @(negedge clk);
      edges++;
    end
    check("latency", 32'(edges), 32'(e_lat));
    check("res_iter", 32'(bus.res_iter), 32'(e_iter));
    check("res_escaped", 32'(bus.res_escaped), 32'(e_esc));
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        bus.req_valid = (i % 2 == 0);
        @(negedge clk);
        check("bp_valid", 32'(bus.res_valid), 32'd1);
        check("bp_iter", 32'(bus.res_iter), 32'(e_iter));
        check("bp_esc", 32'(bus.res_escaped), 32'(e_esc));
        check("bp_req_ready", 32'(bus.req_ready), 32'd0);
        check("bp_bus_quiet", 32'(bus.acc_data), 32'd0);
      end
      bus.req_valid = 1'b0;
      bus.res_ready = 1'b1;
    end
    @(negedge clk);
    check("res_valid_drop", 32'(bus.res_valid), 32'd0);
    check("req_ready_back", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests_run        = 0;
    tests_failed     = 0;
    div_at           = 7'd0;
    rst_n            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_cr       = 32'h0;
    bus.req_ci       = 32'h0;
    bus.req_max_iter = 7'd0;
    bus.res_ready    = 1'b1;
    #12;
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_iter", 32'(bus.res_iter), 32'd0);
    check("rst_acc_data", 32'(bus.acc_data), 32'd0);
    check("rst_strobes", {29'd0, bus.acc_start, bus.acc_load_cr, bus.acc_load_ci}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);

    // Byte order, then limit reached with no divergence
    run_req(32'h11223344, 32'hAABBCCDD, 7'd20, 7'd0, 7'd20, 1'b0, 28, 0);
    // Escape before the limit
    run_req(32'h0BADF00D, 32'hDEADBEEF, 7'd20, 7'd5, 7'd5, 1'b1, 13, 0);
    // Divergence coincides with the limit
    run_req(32'h01234567, 32'h89ABCDEF, 7'd20, 7'd20, 7'd20, 1'b1, 28, 0);
    // Zero limit means 127
    run_req(32'hFFFF0000, 32'h0000FFFF, 7'd0, 7'd0, 7'd127, 1'b0, 135, 0);
    // Limit of 1 with backpressure for 10 cycles
    run_req(32'h5A5A5A5A, 32'hA5A5A5A5, 7'd1, 7'd0, 7'd1, 1'b0, 9, 10);

    // Reset during Ci byte 1
    div_at = 7'd0;
    send_req(32'h01020304, 32'h05060708, 7'd10);
    for (int k = 0; k < 5; k++) @(negedge clk);
    check("mid_ci_byte1", 32'(bus.acc_data), 32'h07);
    rst_n = 1'b0;
    #1;
    check("abort_strobes", {29'd0, bus.acc_start, bus.acc_load_cr, bus.acc_load_ci}, 32'd0);
    check("abort_res_valid", 32'(bus.res_valid), 32'd0);
    check("abort_acc_data", 32'(bus.acc_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_no_strobe", {29'd0, bus.acc_start, bus.acc_load_cr, bus.acc_load_ci}, 32'd0);
    check("abort_res_quiet", 32'(bus.res_valid), 32'd0);
    run_req(32'h11223344, 32'hAABBCCDD, 7'd3, 7'd0, 7'd3, 1'b0, 11, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mandelbrot_host_driver.md
MANDELBROT_HOST_DRIVER -- requirements
Module: mandelbrot_host_driver

Interface
REQ-001 SHALL have parameters: none; all widths are fixed (32-bit coordinates, 7-bit iteration count, 8-bit byte bus).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  host request valid.
REQ-005 SHALL have port req_ready  output  1  driver accepts a request; high only in IDLE.
REQ-006 SHALL have port req_cr  input  32  real coordinate, in the accelerator's native format, passed through unmodified.
REQ-007 SHALL have port req_ci  input  32  imaginary coordinate, in the accelerator's native format.
REQ-008 SHALL have port req_max_iter  input  7  iteration limit; 0 means 127.
REQ-009 SHALL have port res_valid  output  1  result valid.
REQ-010 SHALL have port res_ready  input  1  host accepts the result.
REQ-011 SHALL have port res_iter  output  7  iteration count of the finished point.
REQ-012 SHALL have port res_escaped  output  1  1 = the point diverged; 0 = the limit was reached.
REQ-013 SHALL have port acc_data  output  8  byte bus to the accelerator data input.
REQ-014 SHALL have port acc_start  output  1  accelerator start strobe.
REQ-015 SHALL have port acc_load_cr  output  1  accelerator Cr load strobe.
REQ-016 SHALL have port acc_load_ci  output  1  accelerator Ci load strobe.
REQ-017 SHALL have port acc_iter  input  7  accelerator iteration counter, registered on the accelerator side.
REQ-018 SHALL have port acc_unbounded  input  1  accelerator divergence flag, registered on the accelerator side.

Function
REQ-019 SHALL drive all acc_* and res_* outputs directly from flops.
REQ-020 SHALL implement the states IDLE, SEND_CR, SEND_CI, WAIT and RESULT, with a 2-bit byte index.
REQ-021 On a req_valid&&req_ready handshake, SHALL perform the following and enter SEND_CR with byte index 0:
- capture req_cr and req_ci;
- capture the effective limit L (req_max_iter, or 127 when req_max_iter is 0).
REQ-022 In SEND_CR, SHALL drive acc_data with req_cr bytes least-significant byte first, one byte per cycle, over 4 cycles.
REQ-023 SHALL assert acc_load_cr only together with byte 3 of Cr.
REQ-024 In SEND_CI, SHALL drive the Ci bytes least-significant byte first over 4 cycles.
REQ-025 SHALL assert acc_load_ci and acc_start together, and only together with byte 3 of Ci.
REQ-026 SHALL hold acc_start low during every cycle that carries bytes 0-2, because the accelerator shifts bytes only while start is low.
REQ-027 The first request byte SHALL appear in the cycle after the handshake; the start strobe SHALL appear 8 cycles after the handshake.
REQ-028 Each strobe SHALL be exactly one cycle wide.
REQ-029 SHALL drive acc_data = 0x00 in every state other than SEND_CR and SEND_CI.
REQ-030 The edge that samples acc_start SHALL move the FSM to WAIT, so the first WAIT cycle already sees acc_iter=1 and acc_unbounded=0.
REQ-031 In WAIT, SHALL evaluate each cycle in this priority order:
- if acc_unbounded=1, capture res_iter=acc_iter and res_escaped=1, then go to RESULT;
- else if acc_iter==L, capture res_iter=L and res_escaped=0, then go to RESULT;
- otherwise stay in WAIT.
REQ-032 When acc_unbounded=1 and acc_iter==L occur in the same cycle, SHALL report escaped=1.
REQ-033 Worst-case WAIT duration SHALL be L cycles; acc_iter wrap (127->0) SHALL be unreachable because L<=127.
REQ-034 In RESULT, SHALL hold res_valid=1 and keep res_iter and res_escaped stable until res_ready=1.
REQ-035 On the result handshake, SHALL deassert res_valid on the next edge and return to IDLE; req_ready SHALL rise in the following cycle.
REQ-036 SHALL ignore req_valid in every state other than IDLE, where req_ready=0 outside IDLE.
REQ-037 SHALL ignore res_ready when res_valid=0.
REQ-038 SHALL leave the accelerator iterating freely while the driver is in RESULT or IDLE; its outputs are don't-care there.

Reset
REQ-039 While rst_n=0, SHALL asynchronously force:
- state IDLE, byte index 0;
- req_ready=1 after release;
- res_valid=0, res_iter=0, res_escaped=0;
- acc_data=0, acc_start=0, acc_load_cr=0, acc_load_ci=0;
- captured coordinates and L cleared.
REQ-040 Reset asserted mid-SEND or mid-WAIT SHALL abort the transfer with no partial strobe and no result; the next request after release SHALL run a complete 8-byte sequence.

Verification
REQ-041 Byte order: Cr=0x11223344, Ci=0xAABBCCDD -> acc_data = 44,33,22,11(load_cr),DD,CC,BB,AA(load_ci+start), with no gaps and start low on the first 7 bytes.
REQ-042 Limit reached: the bench accelerator model never diverges, req_max_iter=20 -> res_iter=20, res_escaped=0, res_valid 28 cycles after the request handshake.
REQ-043 Escape: the model asserts unbounded at iter 5 with req_max_iter=20 -> res_iter=5, res_escaped=1.
REQ-044 Coincident events and zero limit:
- unbounded at iter 20 with req_max_iter=20 -> res_escaped=1;
- req_max_iter=0 with no divergence -> res_iter=127, res_escaped=0.
REQ-045 Backpressure: hold res_ready=0 for 10 cycles -> res_valid, res_iter and res_escaped stay constant; req_valid pulses during that time are not accepted.
REQ-046 Reset during SEND_CI byte 1 -> all strobes low and res_valid=0 immediately; a following request completes normally with the correct byte sequence.
